// File: rtl/jisuan_out_pkg.sv
// jisuan_out_pkg
// Shared types and constants for the password output collector.
//   - PWD_LEN     : default password width in bytes (from `OUTPUT_LEN)
//   - pwd_t       : one password, PWD_LEN*8 bits
//   - CH_W()      : channel index width, never narrower than one bit
//   - entry_t     : FIFO entry, password plus source channel tag when
//                   JISUAN_OUT_CHID_EN is defined
//   - FOUND_CNT_W : width of the saturating found-result counter
// Optional feature macro: JISUAN_OUT_CHID_EN

`ifndef OUTPUT_LEN
`define OUTPUT_LEN 8
`endif

package jisuan_out_pkg;

  localparam int PWD_LEN     = `OUTPUT_LEN;
  localparam int FOUND_CNT_W = 16;
  localparam int MAX_CH_W    = 4;

  typedef logic [PWD_LEN*8-1:0] pwd_t;

  // $clog2 collapses to 0 for a single channel; keep index vectors legal.
  function automatic int CH_W(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
`ifdef JISUAN_OUT_CHID_EN
    logic [MAX_CH_W-1:0] ch;
`endif
    pwd_t pwd;
  } entry_t;

endpackage

// File: rtl/password_out_mux_rr_arb.sv
// rr_arb
// Purely combinational round-robin arbiter. The search starts at the
// channel after last_grant and wraps modulo N.
//   req        : request vector, one bit per channel
//   last_grant : index of the most recently served channel
//   en         : when low the one-hot grant is suppressed
//   gnt        : one-hot grant (all zero when disabled or no request)
//   gnt_idx    : index of the winning requester (0 when none)

module rr_arb
  import jisuan_out_pkg::*;
#(
  parameter int N = 4,
  localparam int W = CH_W(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last_grant,
  input  logic         en,
  output logic [N-1:0] gnt,
  output logic [W-1:0] gnt_idx
);

  logic [W-1:0] cand;
  logic         hit;

  // Walk the channels starting just after the last winner; the first
  // requester found wins. gnt_idx is computed even while disabled so the
  // data select path does not depend on FIFO space or flush.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    cand    = '0;
    hit     = 1'b0;
    for (int i = 1; i <= N; i++) begin
      cand = W'((int'(last_grant) + i) % N);
      if (!hit && req[cand]) begin
        hit     = 1'b1;
        gnt_idx = cand;
      end
    end
    if (en && hit) begin
      gnt[gnt_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/password_out_mux.sv
// password_out_mux
// Collects found passwords from CH_NUM compute engines through a
// round-robin arbiter into a DEPTH-entry FIFO that drains to a single
// valid/ready output.
//   clk, rst    : clock, asynchronous active-high reset
//   flush       : synchronous FIFO clear (keeps last_grant and found_cnt)
//   in_vld      : per-channel result valid
//   in_rdy      : per-channel accept, at most one bit high
//   password_i  : channel k at [k*OUT_LEN*8 +: OUT_LEN*8]
//   out_vld     : FIFO head valid
//   out_rdy     : downstream accept
//   password_o  : FIFO head password
//   out_ch      : FIFO head source channel (only with JISUAN_OUT_CHID_EN)
//   found_cnt   : accepted-result count, saturating at all ones
// Optional feature macro: JISUAN_OUT_CHID_EN

`ifndef OUTPUT_LEN
`define OUTPUT_LEN 8
`endif

module password_out_mux
  import jisuan_out_pkg::*;
#(
  parameter int CH_NUM  = 4,
  parameter int OUT_LEN = `OUTPUT_LEN,
  parameter int DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic [CH_NUM-1:0]           in_vld,
  output logic [CH_NUM-1:0]           in_rdy,
  input  logic [CH_NUM*OUT_LEN*8-1:0] password_i,
  output logic                        out_vld,
  input  logic                        out_rdy,
  output logic [OUT_LEN*8-1:0]        password_o,
`ifdef JISUAN_OUT_CHID_EN
  output logic [$clog2(CH_NUM)-1:0]   out_ch,
`endif
  output logic [FOUND_CNT_W-1:0]      found_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = OUT_LEN * 8;
  localparam int GW = CH_W(CH_NUM);

  logic [PW-1:0]          mem_pwd [DEPTH];
`ifdef JISUAN_OUT_CHID_EN
  logic [GW-1:0]          mem_ch  [DEPTH];
`endif
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic [AW:0]            count;
  logic [GW-1:0]          last_grant;
  logic [FOUND_CNT_W-1:0] found_q;

  logic                   arb_en;
  logic [GW-1:0]          gnt_idx;
  logic [PW-1:0]          pwd_in;
  logic                   push;
  logic                   pop;

  // Grants are withheld while full, flushing or in reset, so in_rdy has
  // no path from out_rdy; freed space shows up one cycle after a pop.
  assign arb_en = (count < (AW+1)'(DEPTH)) && !flush && !rst;

  rr_arb #(.N(CH_NUM)) u_arb (
    .req        (in_vld),
    .last_grant (last_grant),
    .en         (arb_en),
    .gnt        (in_rdy),
    .gnt_idx    (gnt_idx)
  );

  assign push   = |in_rdy;
  assign pop    = out_vld && out_rdy;
  assign pwd_in = password_i[gnt_idx*PW +: PW];

  assign out_vld    = (count != '0);
  assign password_o = mem_pwd[rd_ptr];
`ifdef JISUAN_OUT_CHID_EN
  assign out_ch     = mem_ch[rd_ptr];
`endif
  assign found_cnt  = found_q;

  // FIFO storage, pointers, arbiter history and the result counter.
  // Flush only empties the FIFO; a pop presented on the flush edge is
  // dropped and the arbiter has already refused any push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      last_grant <= GW'(CH_NUM - 1);
      found_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_pwd[i] <= '0;
`ifdef JISUAN_OUT_CHID_EN
        mem_ch[i]  <= '0;
`endif
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem_pwd[wr_ptr] <= pwd_in;
`ifdef JISUAN_OUT_CHID_EN
        mem_ch[wr_ptr]  <= gnt_idx;
`endif
        wr_ptr     <= wr_ptr + 1'b1;
        last_grant <= gnt_idx;
        if (found_q != '1) begin
          found_q <= found_q + 1'b1;
        end
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_password_out_mux.sv
// tb_password_out_mux
// Directed bench for password_out_mux (CH_NUM=4, OUT_LEN=4, DEPTH=4).
// Stimulus pushes the expected result of every accepted request into a
// scoreboard queue; a separate monitor pops and compares whenever the
// DUT's output handshake fires.
// Optional feature macro: JISUAN_OUT_CHID_EN

module tb_password_out_mux;

  localparam int CH_NUM  = 4;
  localparam int OUT_LEN = 4;
  localparam int DEPTH   = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic [3:0]   in_vld;
  logic [3:0]   in_rdy;
  logic [127:0] password_i;
  logic         out_vld;
  logic         out_rdy;
  logic [31:0]  password_o;
`ifdef JISUAN_OUT_CHID_EN
  logic [1:0]   out_ch;
`endif
  logic [15:0]  found_cnt;

  typedef struct {
    logic [31:0] pwd;
    logic [1:0]  ch;
  } exp_t;

  exp_t        sb[$];
  exp_t        head;
  int          compared_cnt = 0;
  int          mismatch_cnt = 0;
  int          seq[4] = '{0, 0, 0, 0};
  logic [15:0] exp_found = '0;

  password_out_mux #(
    .CH_NUM  (CH_NUM),
    .OUT_LEN (OUT_LEN),
    .DEPTH   (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_vld     (in_vld),
    .in_rdy     (in_rdy),
    .password_i (password_i),
    .out_vld    (out_vld),
    .out_rdy    (out_rdy),
    .password_o (password_o),
`ifdef JISUAN_OUT_CHID_EN
    .out_ch     (out_ch),
`endif
    .found_cnt  (found_cnt)
  );

  always #5 clk = ~clk;

  // Each channel's n-th result has a unique pattern; channel 2's first
  // result is the all-A5 word.
  function automatic logic [31:0] chanPwd(input int k, input int s);
    if (k == 2 && s == 0) return 32'hA5A5_A5A5;
    return {8'hC0 + 8'(k), 8'h5A, 16'(s)};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    compared_cnt++;
    if (act !== exp) begin
      mismatch_cnt++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One cycle: drive inputs just after the rising edge, check the
  // arbiter at the falling edge, and record what the next edge accepts.
  task automatic applyStimulus(input logic [3:0] vld, input logic ordy,
                               input logic fl, input logic [3:0] exp_rdy);
    in_vld  = vld;
    out_rdy = ordy;
    flush   = fl;
    for (int k = 0; k < 4; k++) password_i[k*32 +: 32] = chanPwd(k, seq[k]);
    @(negedge clk);
    checkOutput("in_rdy", {28'b0, in_rdy}, {28'b0, exp_rdy});
    checkOutput("found_cnt", {16'b0, found_cnt}, {16'b0, exp_found});
    if (fl) sb.delete();
    for (int k = 0; k < 4; k++) begin
      if (exp_rdy[k]) begin
        sb.push_back('{chanPwd(k, seq[k]), 2'(k)});
        seq[k]++;
        if (exp_found != 16'hFFFF) exp_found++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset();
    rst     = 1'b1;
    in_vld  = '0;
    out_rdy = 1'b0;
    flush   = 1'b0;
    sb.delete();
    exp_found = '0;
    @(negedge clk);
    checkOutput("rst_in_rdy", {28'b0, in_rdy}, 32'd0);
    checkOutput("rst_out_vld", {31'b0, out_vld}, 32'd0);
    checkOutput("rst_password_o", password_o, 32'd0);
    checkOutput("rst_found_cnt", {16'b0, found_cnt}, 32'd0);
`ifdef JISUAN_OUT_CHID_EN
    checkOutput("rst_out_ch", {30'b0, out_ch}, 32'd0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: every output handshake must match the oldest expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && out_vld && out_rdy) begin
        if (sb.size() == 0) begin
          compared_cnt++;
          mismatch_cnt++;
          $display("[TB] FAIL unexpected_pop: got %h expected no output", password_o);
        end else begin
          head = sb.pop_front();
          checkOutput("pop_pwd", password_o, head.pwd);
`ifdef JISUAN_OUT_CHID_EN
          checkOutput("pop_ch", {30'b0, out_ch}, {30'b0, head.ch});
`endif
        end
      end
    end
  end

  initial begin
    rst        = 1'b1;
    flush      = 1'b0;
    in_vld     = '0;
    out_rdy    = 1'b0;
    password_i = '0;
    #2;
    applyReset();

    // Single request on channel 2, visible at the output one edge later.
    applyStimulus(4'b0100, 1'b1, 1'b0, 4'b0100);
    checkOutput("latency_out_vld", {31'b0, out_vld}, 32'd1);
    checkOutput("latency_pwd", password_o, 32'hA5A5_A5A5);
`ifdef JISUAN_OUT_CHID_EN
    checkOutput("latency_ch", {30'b0, out_ch}, 32'd2);
`endif
    applyStimulus(4'b0000, 1'b1, 1'b0, 4'b0000);

    // All channels valid, output always ready: rotation resumes after ch2.
    applyStimulus(4'b1111, 1'b1, 1'b0, 4'b1000);
    applyStimulus(4'b1111, 1'b1, 1'b0, 4'b0001);
    applyStimulus(4'b1111, 1'b1, 1'b0, 4'b0010);
    applyStimulus(4'b1111, 1'b1, 1'b0, 4'b0100);
    applyStimulus(4'b1111, 1'b1, 1'b0, 4'b1000);
    applyStimulus(4'b1111, 1'b1, 1'b0, 4'b0001);
    applyStimulus(4'b1111, 1'b1, 1'b0, 4'b0010);
    applyStimulus(4'b1111, 1'b1, 1'b0, 4'b0100);
    applyStimulus(4'b0000, 1'b1, 1'b0, 4'b0000);

    // Back-pressure: exactly DEPTH pushes ch0..3, then refusal until a pop.
    applyReset();
    applyStimulus(4'b1111, 1'b0, 1'b0, 4'b0001);
    applyStimulus(4'b1111, 1'b0, 1'b0, 4'b0010);
    applyStimulus(4'b1111, 1'b0, 1'b0, 4'b0100);
    applyStimulus(4'b1111, 1'b0, 1'b0, 4'b1000);
    applyStimulus(4'b1111, 1'b0, 1'b0, 4'b0000);
    applyStimulus(4'b1111, 1'b1, 1'b0, 4'b0000);
    applyStimulus(4'b1111, 1'b1, 1'b0, 4'b0001);
    for (int i = 0; i < 4; i++) applyStimulus(4'b0000, 1'b1, 1'b0, 4'b0000);
    checkOutput("drain_out_vld", {31'b0, out_vld}, 32'd0);

    // Pointer wrap: fill, pop two, push two, drain.
    applyStimulus(4'b1111, 1'b0, 1'b0, 4'b0010);
    applyStimulus(4'b1111, 1'b0, 1'b0, 4'b0100);
    applyStimulus(4'b1111, 1'b0, 1'b0, 4'b1000);
    applyStimulus(4'b1111, 1'b0, 1'b0, 4'b0001);
    applyStimulus(4'b0000, 1'b1, 1'b0, 4'b0000);
    applyStimulus(4'b0000, 1'b1, 1'b0, 4'b0000);
    applyStimulus(4'b1111, 1'b0, 1'b0, 4'b0010);
    applyStimulus(4'b1111, 1'b0, 1'b0, 4'b0100);
    for (int i = 0; i < 4; i++) applyStimulus(4'b0000, 1'b1, 1'b0, 4'b0000);
    checkOutput("wrap_out_vld", {31'b0, out_vld}, 32'd0);

    // Flush with three entries queued and channel 1 requesting.
    applyStimulus(4'b1111, 1'b0, 1'b0, 4'b1000);
    applyStimulus(4'b1111, 1'b0, 1'b0, 4'b0001);
    applyStimulus(4'b1111, 1'b0, 1'b0, 4'b0010);
    applyStimulus(4'b0010, 1'b0, 1'b1, 4'b0000);
    checkOutput("flush_out_vld", {31'b0, out_vld}, 32'd0);
    applyStimulus(4'b0010, 1'b0, 1'b0, 4'b0010);

    // Reset asserted in the middle of a burst takes effect immediately.
    applyStimulus(4'b1111, 1'b1, 1'b0, 4'b0100);
    applyStimulus(4'b1111, 1'b1, 1'b0, 4'b1000);
    rst = 1'b1;
    #1;
    checkOutput("midrst_in_rdy", {28'b0, in_rdy}, 32'd0);
    checkOutput("midrst_out_vld", {31'b0, out_vld}, 32'd0);
    checkOutput("midrst_password_o", password_o, 32'd0);
    checkOutput("midrst_found_cnt", {16'b0, found_cnt}, 32'd0);
    sb.delete();
    exp_found = '0;
    in_vld    = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Saturation of the result counter.
    force dut.found_q = 16'hFFFE;
    #1;
    release dut.found_q;
    exp_found = 16'hFFFE;
    applyStimulus(4'b1111, 1'b1, 1'b0, 4'b0001);
    applyStimulus(4'b1111, 1'b1, 1'b0, 4'b0010);
    applyStimulus(4'b1111, 1'b1, 1'b0, 4'b0100);
    applyStimulus(4'b0000, 1'b1, 1'b0, 4'b0000);
    applyStimulus(4'b0000, 1'b1, 1'b0, 4'b0000);
    checkOutput("sat_found_cnt", {16'b0, found_cnt}, 32'h0000_FFFF);
    checkOutput("sb_empty", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared_cnt, mismatch_cnt);
    $finish;
  end

endmodule

// File: doc/password_out_mux.md
# password_out_mux

Multi-channel result collector for the password search datapath. Each of CH_NUM compute engines presents found passwords on its own valid/ready channel. A round-robin arbiter accepts at most one result per cycle into a DEPTH-entry FIFO, which drains to a single valid/ready password output of OUT_LEN bytes. This is the parametrised replacement for the single-channel password output path.

## Interface
- CH_NUM, 4: number of input channels, 2..16
- OUT_LEN, `OUTPUT_LEN: password width in bytes
- DEPTH, 4: FIFO entries, power of two, ≥2
- clk  input  1  single clock, rising edge
- rst  input  1  reset; asynchronous and active-high
- flush  input  1  synchronous FIFO clear
- in_vld  input  CH_NUM  per-channel result valid
- in_rdy  output  CH_NUM  per-channel accept, at most one bit high
- password_i  input  CH_NUM*OUT_LEN*8  channel k occupies bits [k*OUT_LEN*8 +: OUT_LEN*8]
- out_vld  output  1  FIFO head valid
- out_rdy  input  1  downstream accept
- password_o  output  OUT_LEN*8  FIFO head password
- out_ch  output  $clog2(CH_NUM)  source channel of head (only with JISUAN_OUT_CHID_EN)
- found_cnt  output  16  total results accepted, saturating

## Operation
- Transfer on any port occurs when vld&&rdy at a rising clk edge.
- Arbiter: round-robin over in_vld, starting the search at last_grant+1 (mod CH_NUM). last_grant resets to CH_NUM-1, so channel 0 has first priority.
- in_rdy[k] = (grant==k) && in_vld[k] && (count<DEPTH) && !flush. in_rdy never depends on out_rdy.
- last_grant updates only on an accepted push, never on a refused request.
- FIFO: wr_ptr/rd_ptr are $clog2(DEPTH) bits and wrap naturally. count is $clog2(DEPTH)+1 bits.
- out_vld = (count!=0). password_o/out_ch are driven directly from mem[rd_ptr].
- Push and pop in the same cycle: count is unchanged and both pointers advance. When the FIFO is full, a push is impossible, so a pop alone occurs.
- flush: the pointers and count go to 0 at the edge. A pop in the same cycle is discarded and no push is accepted. last_grant and found_cnt are kept.
- found_cnt increments on every accepted push and saturates at 16'hFFFF. It is cleared only by rst.
- Data on a non-granted channel must be held by the source. Per the protocol, a source must not drop in_vld before its handshake.

## Timing
- Reset values: in_rdy=0, out_vld=0, password_o=0 (mem cleared), out_ch=0, found_cnt=0, count=0, pointers=0, last_grant=CH_NUM-1.
- rst asserted mid-operation clears all state immediately. FIFO contents are lost.
- Latency: a push accepted at edge N gives out_vld=1 and valid data after edge N, so it can be popped at edge N+1.
- in_rdy is combinational from in_vld, count and flush. It has no combinational path from out_rdy.
- Throughput: one push and one pop per cycle sustained. With CH_NUM channels all valid, each channel is served once every CH_NUM accepted pushes.
- Full: all in_rdy are 0 until a pop has taken effect, so space is visible one cycle after the pop.

## Configuration
- JISUAN_OUT_CHID_EN defined:
  - each FIFO entry stores the grant index alongside the password;
  - out_ch is present and valid whenever out_vld=1.
- Not defined:
  - out_ch port and tag storage are absent;
  - entries hold only OUT_LEN*8 bits;
  - all other behaviour is identical.

## Structure
- Package jisuan_out_pkg holds:
  - typedef pwd_t (logic [OUT_LEN*8-1:0]);
  - function clog2-safe CH_W;
  - the FIFO entry struct (pwd plus optional ch tag under the macro);
  - localparam FOUND_CNT_W=16.
- Sub-module rr_arb (parameter N) maps request vector, last_grant and enable to a one-hot grant and a grant index. It is purely combinational. The last_grant register lives in password_out_mux.
- FIFO storage is inline: mem plus pointers. No separate FIFO module.

## Test plan
- Reset, then out_rdy=1 and only channel 2 valid with 0xA5.. -> in_rdy=4'b0100 and out_vld rises the next cycle with that password. With the macro, out_ch=2. found_cnt=1.
- All 4 channels valid continuously, out_rdy=1 -> grant order 0,1,2,3,0,…, one transfer per cycle, found_cnt increments by 1 per cycle.
- out_rdy=0, all channels valid -> exactly DEPTH=4 pushes (ch0..3), then in_rdy=0. Raise out_rdy -> pops in order 0,1,2,3, and the push after the first pop is ch0.
- Full FIFO with wrap: fill 4, pop 2, push 2, drain -> output order matches push order across the pointer wrap. count returns to 0 and out_vld=0.
- flush asserted while count=3 and ch1 valid -> no in_rdy that cycle, out_vld=0 the next cycle, found_cnt unchanged. Assert rst mid-burst -> all outputs at reset values immediately.
- Force found_cnt to 16'hFFFE, accept 3 results -> found_cnt reads 16'hFFFF and holds.
